// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller.
//
// Drives the external sample/hold switch and R-2R DAC and resolves one bit per settle window
// from the (asynchronous) comparator. Each finished code is presented on Dout together with a
// one-cycle Dvalid strobe.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   start       single-shot conversion request, sampled only while idle
//   continuous  1 = run conversions back-to-back
//   cmp_in      asynchronous comparator output, 1 = Vin >= Vdac(dac_code)
//   sample_hold 1 = S/H switch closed (tracking)
//   dac_code    trial code to the DAC
//   busy        1 whenever a conversion is in progress
//   Dout        last completed result, held between conversions
//   Dvalid      one-cycle pulse in the cycle Dout takes a new value
module sar_adc_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned TRACK_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             cmp_in,
  output logic             sample_hold,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] Dout,
  output logic             Dvalid
);

  localparam int unsigned CntMax = (TRACK_CYCLES > SETTLE_CYCLES) ? TRACK_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CntW-1:0] TrackLast  = CntW'(TRACK_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxTop     = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StTrack, StTrial, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             cmp_meta_q, cmp_s_q;
  logic [WIDTH-1:0] bit_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      dout_q     <= '0;
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      dout_q     <= dout_d;
      cmp_meta_q <= cmp_in;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  assign bit_mask = WIDTH'(1) << idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    result_d    = result_q;
    dout_d      = dout_q;
    sample_hold = 1'b0;
    dac_code    = '0;
    Dvalid      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start || continuous) begin
          state_d = StTrack;
          cnt_d   = '0;
        end
      end

      StTrack: begin
        sample_hold = 1'b1;
        result_d    = '0;
        if (cnt_q == TrackLast) begin
          state_d = StTrial;
          cnt_d   = '0;
          idx_d   = IdxTop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StTrial: begin
        dac_code = result_q | bit_mask;
        if (cnt_q == SettleLast) begin
          cnt_d    = '0;
          result_d = cmp_s_q ? (result_q | bit_mask) : result_q;
          if (idx_q == '0) begin
            state_d = StDone;
            // Load Dout here so the new code is on the pins in the same cycle as Dvalid.
            dout_d  = result_d;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        Dvalid   = 1'b1;
        dac_code = result_q;
        cnt_d    = '0;
        state_d  = continuous ? StTrack : StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign Dout = dout_q;

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation controller for the discrete ADC front end. It sits directly upstream of the sample averager. Each conversion works as follows:
- Drives the external sample/hold switch and the 8-bit R-2R DAC.
- Resolves one bit per settle window from the external comparator.
- Presents each finished code on Dout with a one-cycle Dvalid strobe. Dvalid connects straight to the averager's EN, and Dout to its Din.

Parameters:
WIDTH, 8, conversion resolution in bits; sets the dac_code and Dout widths.
TRACK_CYCLES, 4, clocks sample_hold is held high (track phase) before bit trials; legal range >=1.
SETTLE_CYCLES, 8, clocks per bit trial (DAC settle plus comparator sync); legal range >=3.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset (asserted when 0).
start  in  1  single-shot conversion request; sampled only in IDLE.
continuous  in  1  when 1, conversions back-to-back with no IDLE gap.
cmp_in  in  1  asynchronous comparator output; 1 = Vin >= Vdac(dac_code).
sample_hold  out  1  1 = S/H switch closed (tracking); 0 = hold.
dac_code  out  WIDTH  trial code driven to the R-2R DAC.
busy  out  1  1 whenever state != IDLE.
Dout  out  WIDTH  last completed conversion result; held between conversions.
Dvalid  out  1  one-cycle pulse when Dout updates.

Behaviour:
- Reset: reset=0 at a clock edge forces the following, with no Dvalid:
  - state=IDLE, sample_hold=0, dac_code=0, busy=0, Dout=0, Dvalid=0.
  - Comparator sync flops and result register cleared.
  - Any conversion in flight is aborted.
- cmp_in passes through a 2-flop synchronizer (cmp_s) before use. Only cmp_s is ever used for decisions.
- States: IDLE, TRACK, TRIAL, DONE.
- IDLE:
  - Outputs: dac_code=0, sample_hold=0.
  - Exits to TRACK when (start | continuous)=1.
  - The cycle start is seen is cycle 0.
- TRACK (cycles 1..TRACK_CYCLES):
  - Outputs: sample_hold=1, dac_code=0, result register cleared.
  - After TRACK_CYCLES clocks goes to TRIAL with bit index = WIDTH-1.
- TRIAL:
  - Each bit lasts SETTLE_CYCLES clocks.
  - Combinational output: dac_code = result | (1<<index); sample_hold=0.
  - On the last clock of the window: result[index] <= cmp_s.
  - If index==0, go to DONE; otherwise index decrements and a new window starts.
- DONE (one clock):
  - Dout <= result, including the final bit decision; Dvalid=1 this cycle only; dac_code = result.
  - Next state: TRACK if continuous=1, otherwise IDLE.
- Latency and throughput:
  - Dvalid is asserted in cycle 1 + TRACK_CYCLES + WIDTH*SETTLE_CYCLES (69 at defaults).
  - Continuous mode: one result every TRACK_CYCLES + WIDTH*SETTLE_CYCLES + 1 clocks (69 at defaults).
- start while busy=1 is ignored, not queued.
- continuous deasserted mid-conversion: the current conversion completes and Dvalid fires, then the block returns to IDLE.
- Both start=1 and continuous=1 in IDLE: a single entry into TRACK (same as either one alone).
- Arithmetic: unsigned codes only; no carries; dac_code never exceeds 2^WIDTH-1.
- Dout is stable whenever Dvalid=0; it changes only in the cycle Dvalid=1.
- Decision timing: cmp_s on the last TRIAL clock reflects cmp_in from 2 clocks earlier, i.e. after dac_code has been stable for SETTLE_CYCLES-2 clocks.

Test Plan:
1. Comparator model cmp_in = (vin >= dac_code) with vin=0x10; pulse start once.
   Required: Dvalid single pulse at cycle 69 after start; Dout=0x10; dac_code trial sequence 0x80, 0x40, 0x20, 0x10, 0x18, 0x14, 0x12, 0x11; busy=0 after DONE.
2. vin sweep 0x00, 0x05, 0x55, 0xB7, 0xFF, one start each.
   Required: Dout equals vin exactly each time; 0x00 and 0xFF endpoints are correct.
3. continuous=1 with vin=0x55, run 5 conversions.
   Required: Dvalid pulses exactly 69 clocks apart; sample_hold high 4 clocks before each conversion; no IDLE cycle between conversions.
4. Extra start pulses during TRIAL.
   Required: no extra conversion and no timing change.
   Drop continuous mid-TRIAL: that conversion completes (Dvalid=1), then IDLE.
5. Assert reset=0 during the 5th bit trial.
   Required: next edge gives sample_hold=0, dac_code=0, Dout=0, busy=0, and no Dvalid.
   After release plus a start: a normal conversion completes.
6. Chain into the averager (power=8): continuous=1, vin=0xB7 with ±4 random noise, per-conversion vin updates.
   Required: averager Q[15:8] settles to 0xB7 ±1 after 512 Dvalid pulses.
